// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between N byte sources.
// Define UART_ARB_LOCK_EN to keep the grant on one requester until its req_last byte.
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic [8*N-1:0]       req_data_i,
  input  logic [N-1:0]         req_last_i,
  output logic [N-1:0]         ack_o,
  output logic                 tx_send_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic [$clog2(N)-1:0] grant_id_o,
  output logic                 active_o,
  output logic                 err_timeout_o
);

  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;
  localparam int CW = ($clog2(BUSY_TIMEOUT + 1) > 4) ? $clog2(BUSY_TIMEOUT + 1) : 4;

  localparam logic [SW-1:0] N_S      = SW'(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] TIMEOUT  = CW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e        state_q;
  logic [IW-1:0] rrPtr_q;
  logic [CW-1:0] timeoutCnt_q;
  logic          lock_q;

  logic [N-1:0]  reqEff;
  logic [SW-1:0] scanSum;
  logic          selValid;
  logic [IW-1:0] selIdx;
  logic [7:0]    selData;
  logic [N-1:0]  selOneHot;
  logic [IW-1:0] rrPtr_d;
  logic          lockOnAccept;

  // A held lock narrows the candidate set to the requester that owns the packet.
  always_comb begin
    reqEff = req_i;
    if (lock_q) begin
      reqEff             = '0;
      reqEff[grant_id_o] = req_i[grant_id_o];
    end
  end

  always_comb begin
    selValid = 1'b0;
    selIdx   = rrPtr_q;
    scanSum  = '0;
    for (int k = 0; k < N; k++) begin
      scanSum = {1'b0, rrPtr_q} + SW'(k);
      if (scanSum >= N_S) begin
        scanSum = scanSum - N_S;
      end
      if (!selValid && reqEff[scanSum[IW-1:0]]) begin
        selValid = 1'b1;
        selIdx   = scanSum[IW-1:0];
      end
    end
  end

  always_comb begin
    selData   = '0;
    selOneHot = '0;
    for (int k = 0; k < N; k++) begin
      if (selIdx == IW'(k)) begin
        selData      = req_data_i[8*k +: 8];
        selOneHot[k] = 1'b1;
      end
    end
  end

  assign rrPtr_d = (grant_id_o == LAST_IDX) ? '0 : grant_id_o + 1'b1;

`ifdef UART_ARB_LOCK_EN
  assign lockOnAccept = ~req_last_i[selIdx];
`else
  logic unusedLast;
  assign unusedLast   = ^req_last_i;
  assign lockOnAccept = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ack_o         <= '0;
      tx_send_o     <= 1'b0;
      tx_data_o     <= '0;
      grant_id_o    <= '0;
      active_o      <= 1'b0;
      err_timeout_o <= 1'b0;
      rrPtr_q       <= '0;
      timeoutCnt_q  <= '0;
      lock_q        <= 1'b0;
    end else begin
      ack_o         <= '0;
      tx_send_o     <= 1'b0;
      err_timeout_o <= 1'b0;
      case (state_q)
        IDLE: begin
          // tx_busy also covers a frame still shifting out after an arbiter reset.
          if (!tx_busy_i && selValid) begin
            tx_data_o  <= selData;
            grant_id_o <= selIdx;
            ack_o      <= selOneHot;
            lock_q     <= lockOnAccept;
            active_o   <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_send_o    <= 1'b1;
          timeoutCnt_q <= '0;
          state_q      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (timeoutCnt_q == TIMEOUT) begin
            err_timeout_o <= 1'b1;
            lock_q        <= 1'b0;
            rrPtr_q       <= rrPtr_d;
            active_o      <= 1'b0;
            state_q       <= IDLE;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            if (!lock_q) begin
              rrPtr_q <= rrPtr_d;
            end
            active_o <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          active_o <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  ackOneHot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_o));
  sendAfterAck: assert property (@(posedge clk) disable iff (!rst_n) (|ack_o) |=> tx_send_o);
  sendSingle: assert property (@(posedge clk) disable iff (!rst_n) tx_send_o |=> !tx_send_o);
  activeMatch: assert property (@(posedge clk) disable iff (!rst_n) active_o == (state_q != IDLE));
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued byte sources, a busy model of the
// serializer, and expected (grant, data) pairs popped on every tx_send pulse.
module tb_uart_tx_arbiter;

  localparam int NCH     = 4;
  localparam int TIMEOUT = 15;
  localparam int FRAME   = 10;
  localparam int DEPTH   = 16;

  logic             clk        = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   reqVec;
  logic [8*NCH-1:0] reqData;
  logic [NCH-1:0]   reqLast;
  logic [NCH-1:0]   ackVec;
  logic             txSend;
  logic [7:0]       txData;
  logic             txBusy;
  logic [1:0]       grantId;
  logic             active;
  logic             errTimeout;

  logic forceBusy = 1'b1;
  logic modelEn   = 1'b1;
  int   busyLeft  = 0;
  int   cycle     = 0;

  logic [7:0] chanMem     [NCH][DEPTH];
  logic       chanLastMem [NCH][DEPTH];
  int         chanHead    [NCH];
  int         chanTail    [NCH];

  logic [9:0] expQ [$];
  logic [9:0] expEntry;
  int         vectorCount = 0;
  int         missCount   = 0;
  int         errSeen     = 0;

  uart_tx_arbiter #(
    .N            (NCH),
    .BUSY_TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (reqVec),
    .req_data_i    (reqData),
    .req_last_i    (reqLast),
    .ack_o         (ackVec),
    .tx_send_o     (txSend),
    .tx_data_o     (txData),
    .tx_busy_i     (txBusy),
    .grant_id_o    (grantId),
    .active_o      (active),
    .err_timeout_o (errTimeout)
  );

  always #5 clk = ~clk;

  // Serializer stand-in: busy for FRAME cycles after an accepted send, not reset by rst_n.
  assign txBusy = forceBusy | (busyLeft != 0);

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (busyLeft != 0) begin
      busyLeft <= busyLeft - 1;
    end else if (modelEn && txSend) begin
      busyLeft <= FRAME;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [7:0] data, input logic last);
    chanMem[ch][chanTail[ch]]     = data;
    chanLastMem[ch][chanTail[ch]] = last;
    chanTail[ch]                  = chanTail[ch] + 1;
  endtask

  task automatic expectSend(input logic [1:0] id, input logic [7:0] data);
    expQ.push_back({id, data});
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitDrain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = (expQ.size() == 0) && !active && !txBusy;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  // Requester sources: hold req with the head byte until acked, then present the next.
  initial begin
    reqVec  = '0;
    reqData = '0;
    reqLast = '0;
    for (int i = 0; i < NCH; i++) begin
      chanHead[i] = 0;
      chanTail[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (ackVec[i] === 1'b1 && chanHead[i] != chanTail[i]) begin
          chanHead[i] = chanHead[i] + 1;
        end
        if (chanHead[i] != chanTail[i]) begin
          reqVec[i]         = 1'b1;
          reqData[8*i +: 8] = chanMem[i][chanHead[i]];
          reqLast[i]        = chanLastMem[i][chanHead[i]];
        end else begin
          reqVec[i]         = 1'b0;
          reqData[8*i +: 8] = 8'h00;
          reqLast[i]        = 1'b0;
        end
      end
    end
  end

  // Scoreboard consumer: every launch must match the oldest expected (grant, byte).
  initial begin
    forever begin
      @(negedge clk);
      if (errTimeout === 1'b1) begin
        errSeen = errSeen + 1;
      end
      if (txSend === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("sendUnexpected", 32'(txSend), 32'd0);
        end else begin
          expEntry = expQ.pop_front();
          checkOutput("sendGrant", 32'(grantId), 32'(expEntry[9:8]));
          checkOutput("sendData", 32'(txData), 32'(expEntry[7:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic saw;
    logic gotIt;
    int   sendCyc;
    int   delta;
    sendCyc = 0;
    delta   = 0;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstAck", 32'(ackVec), 32'd0);
    checkOutput("rstSend", 32'(txSend), 32'd0);
    checkOutput("rstData", 32'(txData), 32'd0);
    checkOutput("rstGrant", 32'(grantId), 32'd0);
    checkOutput("rstActive", 32'(active), 32'd0);
    checkOutput("rstErr", 32'(errTimeout), 32'd0);

    // Power-up: serializer busy for 20 cycles holds off the first launch.
    $display("[TB] power-up busy hold-off");
    applyStimulus(0, 8'hA5, 1'b1);
    expectSend(2'd0, 8'hA5);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw = saw | txSend | (|ackVec);
    end
    checkOutput("noLaunchWhileBusy", 32'(saw), 32'd0);
    forceBusy = 1'b0;
    @(negedge clk);
    checkOutput("firstAck", 32'(ackVec), 32'h1);
    @(negedge clk);
    checkOutput("firstSend", 32'(txSend), 32'd1);
    checkOutput("firstAckPulse", 32'(ackVec), 32'd0);
    waitDrain("drainPowerUp");

    // All four requesting from pointer 0, then wrap back to channel 0.
    $display("[TB] round-robin order with wrap");
    applyReset();
    applyStimulus(0, 8'h41, 1'b1);
    applyStimulus(0, 8'h45, 1'b1);
    applyStimulus(1, 8'h42, 1'b1);
    applyStimulus(2, 8'h43, 1'b1);
    applyStimulus(3, 8'h44, 1'b1);
    expectSend(2'd0, 8'h41);
    expectSend(2'd1, 8'h42);
    expectSend(2'd2, 8'h43);
    expectSend(2'd3, 8'h44);
    expectSend(2'd0, 8'h45);
    waitDrain("drainRoundRobin");

    // Pointer now at 1: serve channel 1 alone to park it at 2, then 0 beats 1.
    $display("[TB] pointer at 2 with req 0011");
    applyStimulus(1, 8'h51, 1'b1);
    expectSend(2'd1, 8'h51);
    waitDrain("drainPark");
    applyStimulus(0, 8'h60, 1'b1);
    applyStimulus(1, 8'h61, 1'b1);
    expectSend(2'd0, 8'h60);
    expectSend(2'd1, 8'h61);
    waitDrain("drainWrapScan");

    // Serializer ignores the send: timeout, byte dropped, next requester served.
    $display("[TB] busy timeout");
    modelEn = 1'b0;
    applyStimulus(2, 8'h70, 1'b1);
    applyStimulus(3, 8'h71, 1'b1);
    expectSend(2'd2, 8'h70);
    expectSend(2'd3, 8'h71);
    gotIt = 1'b0;
    for (int i = 0; i < 20 && !gotIt; i++) begin
      @(negedge clk);
      if (txSend === 1'b1) begin
        gotIt   = 1'b1;
        sendCyc = cycle;
      end
    end
    checkOutput("timeoutSendSeen", 32'(gotIt), 32'd1);
    gotIt = 1'b0;
    for (int i = 0; i < 40 && !gotIt; i++) begin
      @(negedge clk);
      if (errTimeout === 1'b1) begin
        gotIt = 1'b1;
        delta = cycle - sendCyc;
      end
    end
    checkOutput("timeoutSeen", 32'(gotIt), 32'd1);
    checkOutput("timeoutDelay", 32'(delta), 32'(TIMEOUT + 1));
    checkOutput("timeoutIdle", 32'(active), 32'd0);
    modelEn = 1'b1;
    @(negedge clk);
    checkOutput("timeoutPulse", 32'(errTimeout), 32'd0);
    waitDrain("drainTimeout");

    // Reset while the frame is still shifting: no relaunch until busy drops.
    $display("[TB] reset during WAIT_DONE");
    applyStimulus(1, 8'h80, 1'b1);
    expectSend(2'd1, 8'h80);
    gotIt = 1'b0;
    for (int i = 0; i < 20 && !gotIt; i++) begin
      @(negedge clk);
      gotIt = (txSend === 1'b1);
    end
    checkOutput("rstMidSendSeen", 32'(gotIt), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("activeInFrame", 32'(active), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidActive", 32'(active), 32'd0);
    checkOutput("rstMidGrant", 32'(grantId), 32'd0);
    checkOutput("rstMidData", 32'(txData), 32'd0);
    applyStimulus(2, 8'h90, 1'b1);
    expectSend(2'd2, 8'h90);
    @(negedge clk);
    rst_n = 1'b1;
    saw   = 1'b0;
    gotIt = 1'b0;
    for (int i = 0; i < 40 && !gotIt; i++) begin
      @(negedge clk);
      if (!txBusy) begin
        gotIt = 1'b1;
      end else begin
        saw = saw | txSend | (|ackVec);
      end
    end
    checkOutput("rstBusyFalls", 32'(gotIt), 32'd1);
    checkOutput("rstNoLaunchBusy", 32'(saw), 32'd0);
    waitDrain("drainReset");

    // Three-byte packet on channel 0 competing with channel 1.
    $display("[TB] packet lock behaviour");
    applyReset();
    applyStimulus(0, 8'hB0, 1'b0);
    applyStimulus(0, 8'hB1, 1'b0);
    applyStimulus(0, 8'hB2, 1'b1);
    applyStimulus(1, 8'hC0, 1'b1);
`ifdef UART_ARB_LOCK_EN
    expectSend(2'd0, 8'hB0);
    expectSend(2'd0, 8'hB1);
    expectSend(2'd0, 8'hB2);
    expectSend(2'd1, 8'hC0);
`else
    expectSend(2'd0, 8'hB0);
    expectSend(2'd1, 8'hC0);
    expectSend(2'd0, 8'hB1);
    expectSend(2'd0, 8'hB2);
`endif
    waitDrain("drainPacket");

    checkOutput("errCount", 32'(errSeen), 32'd1);
    checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
